// File: rtl/async_fifo_pkg.sv
// Shared pointer helpers for the async FIFO write and read controllers.
// Functions work on a fixed maximum pointer width; callers zero-extend and slice.
package async_fifo_pkg;

  localparam int unsigned PtrMaxW = 13;

  typedef logic [PtrMaxW-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PtrMaxW-1] = g[PtrMaxW-1];
    for (int i = PtrMaxW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a Gray-coded bus; resets to zero.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q1_q, q2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q1_q <= '0;
      q2_q <= '0;
    end else begin
      q1_q <= d_i;
      q2_q <= q1_q;
    end
  end

  assign q_o = q2_q;

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// Write-side controller of an async FIFO: pointer, full/level flags, RAM write port.
// Optional macro ASYNC_FIFO_WR_ALMOST_FULL_EN adds AFULL_THRESH and wr_almost_full.
module async_fifo_wr_ctrl
  import async_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
`ifdef ASYNC_FIFO_WR_ALMOST_FULL_EN
  ,
  parameter int unsigned AFULL_THRESH = 2**ADDR_WIDTH - 2
`endif
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst_n,
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] wr_din,
  input  logic [ADDR_WIDTH:0]   rd_gptr,
  output logic                  wr_full,
  output logic                  wr_overflow,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH:0]   wr_gptr
`ifdef ASYNC_FIFO_WR_ALMOST_FULL_EN
  ,
  output logic                  wr_almost_full
`endif
);

  localparam int unsigned PtrW = ADDR_WIDTH + 1;

  logic [PtrW-1:0] wbin_q, wbin_d, gptr_q, gptr_d, level_q, level_d, rq2, rq2_bin;
  logic            full_q, full_d, ovf_q, push;
  ptr_t            gray_ext, rbin_ext;

  sync_2ff #(
    .WIDTH (PtrW)
  ) u_rd_sync (
    .clk_i  (wr_clk),
    .rst_ni (wr_rst_n),
    .d_i    (rd_gptr),
    .q_o    (rq2)
  );

  // Gate with reset so the RAM never sees a write while the pointer is held at zero.
  assign push = wr_req & ~full_q & wr_rst_n;

  always_comb begin
    wbin_d   = wbin_q + PtrW'(push);
    gray_ext = bin2gray(ptr_t'(wbin_d));
    gptr_d   = gray_ext[PtrW-1:0];
    rbin_ext = gray2bin(ptr_t'(rq2));
    rq2_bin  = rbin_ext[PtrW-1:0];
    // Full when the write pointer has lapped the read pointer exactly once.
    full_d   = (gptr_d == {~rq2[PtrW-1:PtrW-2], rq2[PtrW-3:0]});
    level_d  = wbin_d - rq2_bin;
  end

  if (PtrW < PtrMaxW) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^{gray_ext[PtrMaxW-1:PtrW], rbin_ext[PtrMaxW-1:PtrW]};
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      wbin_q  <= '0;
      gptr_q  <= '0;
      full_q  <= 1'b0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      gptr_q  <= gptr_d;
      full_q  <= full_d;
      level_q <= level_d;
      ovf_q   <= ovf_q | (wr_req & full_q);
    end
  end

`ifdef ASYNC_FIFO_WR_ALMOST_FULL_EN
  localparam logic [PtrW-1:0] AfThresh = PtrW'(AFULL_THRESH);

  logic afull_q;

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      afull_q <= 1'b0;
    end else begin
      afull_q <= (level_d >= AfThresh);
    end
  end

  assign wr_almost_full = afull_q;
`endif

  assign wr_full     = full_q;
  assign wr_overflow = ovf_q;
  assign wr_level    = level_q;
  assign wr_gptr     = gptr_q;
  assign ram_wr_en   = push;
  assign ram_wr_addr = wbin_q[ADDR_WIDTH-1:0];
  assign ram_wr_data = wr_din;

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Directed bench for async_fifo_wr_ctrl (DATA_WIDTH=8, ADDR_WIDTH=4) with an
// occupancy-count reference model checked every cycle plus literal expectations.
module tb_async_fifo_wr_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_req = 1'b0;
  logic [7:0] wr_din = '0;
  logic [4:0] rd_gptr;
  logic       wr_full, wr_overflow, ram_wr_en;
  logic [4:0] wr_level, wr_gptr;
  logic [3:0] ram_wr_addr;
  logic [7:0] ram_wr_data;
`ifdef ASYNC_FIFO_WR_ALMOST_FULL_EN
  logic       wr_almost_full;
`endif

  int n_vec = 0;
  int n_err = 0;
  int rd_cnt = 0;

  always #5 clk = ~clk;

  function automatic logic [4:0] gray5(input int v);
    int r;
    r = v & 31;
    return 5'(r ^ (r >> 1));
  endfunction

  assign rd_gptr = gray5(rd_cnt);

  async_fifo_wr_ctrl #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (4)
  ) dut (
    .wr_clk         (clk),
    .wr_rst_n       (rst_n),
    .wr_req         (wr_req),
    .wr_din         (wr_din),
    .rd_gptr        (rd_gptr),
    .wr_full        (wr_full),
    .wr_overflow    (wr_overflow),
    .wr_level       (wr_level),
    .ram_wr_en      (ram_wr_en),
    .ram_wr_addr    (ram_wr_addr),
    .ram_wr_data    (ram_wr_data),
    .wr_gptr        (wr_gptr)
`ifdef ASYNC_FIFO_WR_ALMOST_FULL_EN
    ,
    .wr_almost_full (wr_almost_full)
`endif
  );

  // Reference model: counts pushes and the read count as seen after two wr_clk edges.
  int   m_wcnt, m_rq1, m_rq2, m_level;
  logic m_full, m_ovf, m_af, m_acc;
  int   m_occ_next;

  assign m_acc      = wr_req && !m_full && rst_n;
  assign m_occ_next = (m_wcnt + int'(m_acc) - m_rq2) & 31;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wcnt  <= 0;
      m_rq1   <= 0;
      m_rq2   <= 0;
      m_level <= 0;
      m_full  <= 1'b0;
      m_ovf   <= 1'b0;
      m_af    <= 1'b0;
    end else begin
      m_wcnt  <= m_wcnt + int'(m_acc);
      m_level <= m_occ_next;
      m_full  <= (m_occ_next == 16);
      m_af    <= (m_occ_next >= 14);
      m_ovf   <= m_ovf || (wr_req && m_full);
      m_rq1   <= rd_cnt;
      m_rq2   <= m_rq1;
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    cmp(name, act, exp);
  endtask

  task automatic check_all();
    n_vec++;
    cmp("model ram_wr_en", 32'(ram_wr_en), 32'(m_acc));
    cmp("model ram_wr_addr", 32'(ram_wr_addr), 32'(m_wcnt & 15));
    if (m_acc) cmp("model ram_wr_data", 32'(ram_wr_data), 32'(wr_din));
    cmp("model wr_gptr", 32'(wr_gptr), 32'(gray5(m_wcnt)));
    cmp("model wr_full", 32'(wr_full), 32'(m_full));
    cmp("model wr_overflow", 32'(wr_overflow), 32'(m_ovf));
    cmp("model wr_level", 32'(wr_level), 32'(m_level));
`ifdef ASYNC_FIFO_WR_ALMOST_FULL_EN
    cmp("model wr_almost_full", 32'(wr_almost_full), 32'(m_af));
`endif
  endtask

  // Drive inputs just after a falling edge, check, then advance one full cycle.
  task automatic cyc(input logic req, input logic [7:0] d);
    wr_req = req;
    wr_din = d;
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic do_reset();
    wr_req = 1'b0;
    rd_cnt = 0;
    rst_n  = 1'b0;
    #1;
    cyc(1'b0, 8'h00);
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    cyc(1'b0, 8'h00);
    cyc(1'b0, 8'h00);
    lit("reset wr_full", 32'(wr_full), 32'd0);
    lit("reset wr_level", 32'(wr_level), 32'd0);
    lit("reset wr_gptr", 32'(wr_gptr), 32'd0);
    lit("reset wr_overflow", 32'(wr_overflow), 32'd0);
    rst_n = 1'b1;

    // Fill all 16 entries.
    for (int i = 0; i < 16; i++) begin
      wr_req = 1'b1;
      wr_din = 8'(i);
      #1;
      lit("fill ram_wr_addr", 32'(ram_wr_addr), 32'(i));
      lit("fill ram_wr_en", 32'(ram_wr_en), 32'd1);
      cyc(1'b1, 8'(i));
    end
    lit("full wr_full", 32'(wr_full), 32'd1);
    lit("full wr_level", 32'(wr_level), 32'd16);
    lit("full wr_gptr", 32'(wr_gptr), 32'h18);

    // Push while full is dropped and flagged.
    wr_req = 1'b1;
    wr_din = 8'hAA;
    #1;
    lit("ovf ram_wr_en", 32'(ram_wr_en), 32'd0);
    cyc(1'b1, 8'hAA);
    lit("ovf wr_overflow", 32'(wr_overflow), 32'd1);
    lit("ovf wr_level", 32'(wr_level), 32'd16);
    cyc(1'b0, 8'h00);
    lit("ovf sticky", 32'(wr_overflow), 32'd1);

    // Reader frees four entries.
    rd_cnt = 4;
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00);
    lit("drain wr_full", 32'(wr_full), 32'd0);
    lit("drain wr_level", 32'(wr_level), 32'd12);
    wr_req = 1'b1;
    wr_din = 8'h55;
    #1;
    lit("drain next addr", 32'(ram_wr_addr), 32'd0);
    lit("drain next en", 32'(ram_wr_en), 32'd1);
    cyc(1'b1, 8'h55);
    lit("drain ovf held", 32'(wr_overflow), 32'd1);

    // Wrap: 40 pushes, reader trails by 3.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      wr_req = 1'b1;
      wr_din = 8'(i + 8'h40);
      #1;
      lit("wrap ram_wr_addr", 32'(ram_wr_addr), 32'(i % 16));
      cyc(1'b1, 8'(i + 8'h40));
      rd_cnt = (i + 1 >= 3) ? i + 1 - 3 : 0;
      lit("wrap no full", 32'(wr_full), 32'd0);
      if (i == 14) lit("wrap msb 15", 32'(wr_gptr[4]), 32'd0);
      if (i == 15) lit("wrap msb 16", 32'(wr_gptr[4]), 32'd1);
      if (i == 30) lit("wrap msb 31", 32'(wr_gptr[4]), 32'd1);
      if (i == 31) lit("wrap msb 32", 32'(wr_gptr[4]), 32'd0);
    end

    // Asynchronous reset mid-burst at level 9.
    do_reset();
    for (int i = 0; i < 9; i++) cyc(1'b1, 8'(i));
    lit("midrst level 9", 32'(wr_level), 32'd9);
    wr_req = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    lit("midrst ram_wr_en", 32'(ram_wr_en), 32'd0);
    lit("midrst ram_wr_addr", 32'(ram_wr_addr), 32'd0);
    lit("midrst wr_gptr", 32'(wr_gptr), 32'd0);
    lit("midrst wr_level", 32'(wr_level), 32'd0);
    lit("midrst wr_full", 32'(wr_full), 32'd0);
    lit("midrst wr_overflow", 32'(wr_overflow), 32'd0);
    check_all();
    @(negedge clk);
    cyc(1'b1, 8'h00);
    rst_n = 1'b1;

`ifdef ASYNC_FIFO_WR_ALMOST_FULL_EN
    do_reset();
    for (int i = 0; i < 13; i++) cyc(1'b1, 8'(i));
    lit("afull after 13", 32'(wr_almost_full), 32'd0);
    cyc(1'b1, 8'd13);
    lit("afull after 14", 32'(wr_almost_full), 32'd1);
    lit("afull level 14", 32'(wr_level), 32'd14);
    rd_cnt = 1;
    cyc(1'b0, 8'h00);
    cyc(1'b0, 8'h00);
    lit("afull held", 32'(wr_almost_full), 32'd1);
    cyc(1'b0, 8'h00);
    lit("afull level 13", 32'(wr_level), 32'd13);
    lit("afull falls", 32'(wr_almost_full), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/async_fifo_wr_ctrl.md
ASYNC_FIFO_WR_CTRL -- requirements
Module: async_fifo_wr_ctrl

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 8, data word width; ADDR_WIDTH, default 4, RAM address width (depth 2^ADDR_WIDTH, legal range 2..12).
REQ-002 SHALL have ports:
- wr_clk  input  1  write-domain clock.
- wr_rst_n  input  1  reset; asynchronous, active-low.
- wr_req  input  1  push request.
- wr_din  input  DATA_WIDTH  push data.
- rd_gptr  input  ADDR_WIDTH+1  read pointer, Gray code, launched from read clock domain.
- wr_full  output  1  FIFO full.
- wr_overflow  output  1  sticky: push attempted while full.
- wr_level  output  ADDR_WIDTH+1  occupied entries, write-side view.
- ram_wr_en  output  1  RAM write enable.
- ram_wr_addr  output  ADDR_WIDTH  RAM write address.
- ram_wr_data  output  DATA_WIDTH  RAM write data.
- wr_gptr  output  ADDR_WIDTH+1  write pointer, Gray code, registered, to read domain.
- wr_almost_full  output  1  present only with ALMOST_FULL_EN (REQ-016).

Function
REQ-003 SHALL accept a push in any cycle where wr_req=1 and wr_full=0; ram_wr_en SHALL equal wr_req & ~wr_full combinationally, ram_wr_addr = wbin[ADDR_WIDTH-1:0], ram_wr_data = wr_din, so the RAM captures on the same wr_clk edge.
REQ-004 SHALL keep a binary pointer wbin (ADDR_WIDTH+1 bits) incremented by 1 on each accepted push, wrapping modulo 2^(ADDR_WIDTH+1).
REQ-005 SHALL register wr_gptr = Gray(wbin_next) on each edge, so only one bit of wr_gptr changes per edge.
REQ-006 SHALL synchronise rd_gptr through a 2-flop wr_clk synchroniser; the result rq2 is valid 2 wr_clk edges after rd_gptr is stable.
REQ-007 SHALL register wr_full = (Gray(wbin_next) == {~rq2[MSB:MSB-1], rq2[MSB-2:0]}), asserting on the edge of the push that fills the last entry.
REQ-008 wr_full SHALL be pessimistic: deassert no later than 3 wr_clk edges after a read-pointer change, and never assert while the true occupancy is below depth.
REQ-009 SHALL compute wr_level as a register = wbin_next - Bin(rq2), modulo 2^(ADDR_WIDTH+1), with range 0..2^ADDR_WIDTH.
REQ-010 wr_req=1 while wr_full=1: no pointer change, no RAM write, data dropped; wr_overflow SHALL set on the next edge and hold until reset.
REQ-011 Pointer wrap: the MSB toggle at 2^ADDR_WIDTH pushes SHALL distinguish full from empty; equal pointers mean empty (level 0).
REQ-012 A simultaneous push and read-pointer update SHALL be resolved using the value of rq2 at that edge; the level is conservatively high by at most the synchroniser lag.

Reset
REQ-013 On wr_rst_n=0, asynchronously: wbin, wr_gptr, synchroniser flops, wr_level SHALL be 0; wr_full=0; wr_overflow=0; wr_almost_full=0.
REQ-014 Reset mid-operation SHALL discard pointer state immediately; the read domain SHALL be reset concurrently (system rule); ram_wr_en SHALL be 0 while in reset.
REQ-015 Reset deassertion SHALL be synchronised to wr_clk outside this block.

Configuration
REQ-016 With macro ASYNC_FIFO_WR_ALMOST_FULL_EN defined: parameter AFULL_THRESH (default 2^ADDR_WIDTH-2) is added, and wr_almost_full SHALL be registered as (level_next >= AFULL_THRESH). Without the macro: the port, the parameter and the logic SHALL be absent.

Structure
REQ-017 Package async_fifo_pkg SHALL hold the bin2gray/gray2bin functions, shared with the read controller.
REQ-018 The synchroniser SHALL be a separate sub-module sync_2ff (parameter WIDTH, reset value 0), instantiated once.

Verification (DATA_WIDTH=8, ADDR_WIDTH=4, rd_gptr held constant unless stated)
REQ-019 Reset, then 16 pushes of 0x00..0x0F with rd_gptr=0 -> ram_wr_addr 0..15; wr_full=1 after 16th edge; wr_level=16; wr_gptr=Gray(16)=0x18.
REQ-020 While full, push 0xAA -> ram_wr_en=0; wr_overflow=1 next edge and stays 1; wr_level still 16.
REQ-021 While full, rd_gptr moves to Gray(4)=0x06 -> wr_full=0 and wr_level=12 within 3 edges; next push writes address 0.
REQ-022 Wrap: 40 pushes interleaved with rd_gptr following at lag 3 -> wr_gptr MSB toggles at push 16 and 32; no false full; ram_wr_addr wraps 15 -> 0.
REQ-023 Assert wr_rst_n=0 mid-burst at level 9 -> all outputs 0 immediately, without a wr_clk edge.
REQ-024 With ASYNC_FIFO_WR_ALMOST_FULL_EN, AFULL_THRESH=14 -> wr_almost_full rises with the 14th push and falls once wr_level drops to 13.
